// File: rtl/window_motor_ctrl_if.sv
// Command, limit-switch and motor-drive bundle for the window motor controller.
// The master drives commands and switch levels; the slave (controller) drives the motor outputs.
interface window_motor_ctrl_if #(
    parameter int N_WIN = 8
);
    logic [N_WIN-1:0] open_cmd;
    logic [N_WIN-1:0] close_cmd;
    logic [N_WIN-1:0] fault_clr;
    logic [N_WIN-1:0] closed_sw;
    logic [N_WIN-1:0] open_sw;
    logic [N_WIN-1:0] motor_en;
    logic [N_WIN-1:0] motor_dir;
    logic [N_WIN-1:0] busy;
    logic [N_WIN-1:0] fault;

    modport master (
        output open_cmd, close_cmd, fault_clr, closed_sw, open_sw,
        input  motor_en, motor_dir, busy, fault
    );

    modport slave (
        input  open_cmd, close_cmd, fault_clr, closed_sw, open_sw,
        output motor_en, motor_dir, busy, fault
    );
endinterface

// File: rtl/window_motor_ctrl.sv
// Multi-channel window actuator controller: one independent Moore FSM per channel with
// limit-switch stop, jam timeout, reversal dead time and latched faults.
module window_motor_ctrl #(
    parameter int N_WIN        = 8,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DEADTIME_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    window_motor_ctrl_if.slave  bus
);
    localparam int TMAX = (TIMEOUT_CYC > DEADTIME_CYC) ? TIMEOUT_CYC : DEADTIME_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLOSING = 3'd1;
    localparam logic [2:0] S_OPENING = 3'd2;
    localparam logic [2:0] S_DEAD    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] DT_LAST = TW'(DEADTIME_CYC - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_WIN; gi++) begin : g_ch
            logic          op_i, cl_i, clr_i, csw_i, osw_i;
            logic [2:0]    state_q, state_d;
            logic [TW-1:0] timer_q, timer_d;
            logic          pend_q, pend_d;
            logic          en_q, dir_q, busy_q, fault_q;

            assign op_i  = bus.open_cmd[gi];
            assign cl_i  = bus.close_cmd[gi];
            assign clr_i = bus.fault_clr[gi];
            assign csw_i = bus.closed_sw[gi];
            assign osw_i = bus.open_sw[gi];

            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                pend_d  = pend_q;
                // Both limits active at once means a broken sensor: latch a fault from anywhere.
                if (state_q != S_FAULT && csw_i && osw_i) begin
                    state_d = S_FAULT;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (cl_i) begin
                                if (!csw_i) state_d = S_CLOSING;
                            end else if (op_i && !osw_i) begin
                                state_d = S_OPENING;
                            end
                        end
                        S_CLOSING: begin
                            if (csw_i) begin
                                state_d = S_IDLE;
                            end else if (timer_q == TO_LAST) begin
                                state_d = S_FAULT;
                            end else if (op_i && !cl_i) begin
                                state_d = S_DEAD;
                                pend_d  = 1'b0;
                            end else begin
                                timer_d = timer_q + TW'(1);
                            end
                        end
                        S_OPENING: begin
                            if (osw_i) begin
                                state_d = S_IDLE;
                            end else if (timer_q == TO_LAST) begin
                                state_d = S_FAULT;
                            end else if (cl_i) begin
                                state_d = S_DEAD;
                                pend_d  = 1'b1;
                            end else begin
                                timer_d = timer_q + TW'(1);
                            end
                        end
                        S_DEAD: begin
                            if (cl_i)      pend_d = 1'b1;
                            else if (op_i) pend_d = 1'b0;
                            if (timer_q == DT_LAST) begin
                                if (pend_d) state_d = csw_i ? S_IDLE : S_CLOSING;
                                else        state_d = osw_i ? S_IDLE : S_OPENING;
                            end else begin
                                timer_d = timer_q + TW'(1);
                            end
                        end
                        S_FAULT: begin
                            if (clr_i) state_d = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                // Every state entry starts the shared timer from zero.
                if (state_d != state_q) timer_d = '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                    pend_q  <= 1'b0;
                    en_q    <= 1'b0;
                    dir_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                    pend_q  <= pend_d;
                    en_q    <= (state_d == S_CLOSING) || (state_d == S_OPENING);
                    dir_q   <= (state_d == S_CLOSING);
                    busy_q  <= (state_d == S_CLOSING) || (state_d == S_OPENING) ||
                               (state_d == S_DEAD);
                    fault_q <= (state_d == S_FAULT);
                end
            end

            assign bus.motor_en[gi]  = en_q;
            assign bus.motor_dir[gi] = dir_q;
            assign bus.busy[gi]      = busy_q;
            assign bus.fault[gi]     = fault_q;
        end
    endgenerate
endmodule

// File: tb/tb_window_motor_ctrl.sv
// Self-checking bench for window_motor_ctrl: hand-derived vector table plus multi-cycle
// sequences, with expected outputs queued on drive and popped after each clock edge.
module tb_window_motor_ctrl;
    localparam int N = 4;
    localparam int T = 16;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_motor_ctrl_if #(.N_WIN(N)) bus ();

    window_motor_ctrl #(
        .N_WIN(N), .TIMEOUT_CYC(T), .DEADTIME_CYC(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        string    name;
        logic [3:0] op, cl, clr, csw, osw;
        logic [3:0] en, dir, busy, flt;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] en, dir, busy, flt;
        bit         raw_dir;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic add(string name, logic [3:0] op, logic [3:0] cl, logic [3:0] clr,
                       logic [3:0] csw, logic [3:0] osw, logic [3:0] en, logic [3:0] dir,
                       logic [3:0] busy, logic [3:0] flt);
        vec_t v;
        v.name = name; v.op = op; v.cl = cl; v.clr = clr; v.csw = csw; v.osw = osw;
        v.en = en; v.dir = dir; v.busy = busy; v.flt = flt;
        tbl.push_back(v);
    endtask

    task automatic drive(logic [3:0] op, logic [3:0] cl, logic [3:0] clr,
                         logic [3:0] csw, logic [3:0] osw);
        bus.open_cmd  = op;
        bus.close_cmd = cl;
        bus.fault_clr = clr;
        bus.closed_sw = csw;
        bus.open_sw   = osw;
    endtask

    task automatic expect_out(string name, logic [3:0] en, logic [3:0] dir,
                              logic [3:0] busy, logic [3:0] flt, bit raw_dir);
        exp_t e;
        e.name = name; e.en = en; e.dir = dir; e.busy = busy; e.flt = flt;
        e.raw_dir = raw_dir;
        sb.push_back(e);
    endtask

    // Direction is only compared where the motor runs, except in reset where it must be 0.
    task automatic check_now();
        exp_t       e;
        logic [3:0] a_dir, e_dir;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got no expectation, required one queued entry");
        end else begin
            e = sb.pop_front();
            a_dir = e.raw_dir ? bus.motor_dir : (bus.motor_dir & bus.motor_en);
            e_dir = e.raw_dir ? e.dir : (e.dir & e.en);
            if ({bus.motor_en, a_dir, bus.busy, bus.fault} !== {e.en, e_dir, e.busy, e.flt}) begin
                n_err++;
                $display("FAIL %s: en/dir/busy/fault got %b/%b/%b/%b required %b/%b/%b/%b",
                         e.name, bus.motor_en, a_dir, bus.busy, bus.fault,
                         e.en, e_dir, e.busy, e.flt);
            end else begin
                $display("ok   %s: en/dir/busy/fault=%b/%b/%b/%b",
                         e.name, bus.motor_en, a_dir, bus.busy, bus.fault);
            end
        end
    endtask

    task automatic step(string name, logic [3:0] op, logic [3:0] cl, logic [3:0] clr,
                        logic [3:0] csw, logic [3:0] osw, logic [3:0] en, logic [3:0] dir,
                        logic [3:0] busy, logic [3:0] flt);
        drive(op, cl, clr, csw, osw);
        expect_out(name, en, dir, busy, flt, 1'b0);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal close, limit stop with channel 3 still running
        add("b_close_all", 4'b0000, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
        for (int i = 0; i < 4; i++)
            add("b_run",   4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
        add("b_limit1",    4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
        add("b_limit3",    4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Reversal on channel 2 with four dead cycles
        add("c_open2",     4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        add("c_run",       4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        add("c_run",       4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        add("c_rev",       4'b0000, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int i = 0; i < D - 1; i++)
            add("c_dead",  4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        add("c_resume",    4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        add("c_stop",      4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset state
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        check_now();
        rst_n = 1'b1;

        // Async reset mid-motion, no dead time after release
        step("a_close0",  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        step("a_run0",    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("a_async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        check_now();
        @(posedge clk);
        #1;
        expect_out("a_rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        check_now();
        rst_n = 1'b1;
        step("a_close_after_rst", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        step("a_limit0",  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].op, tbl[i].cl, tbl[i].clr, tbl[i].csw, tbl[i].osw,
                 tbl[i].en, tbl[i].dir, tbl[i].busy, tbl[i].flt);

        // Jam timeout on channel 3; a repeated open mid-run must not restart the timer
        step("d_open3",   4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        for (int i = 1; i < T; i++)
            step("d_run", (i == 5) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0000,
                 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        step("d_jam",     4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        step("d_cmd_in_fault", 4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        step("d_clr_and_cmd",  4'b1000, 4'b0000, 4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("d_cmd_after_clr",4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        step("d_open_limit",   4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Close priority, then sensor inconsistency on idle channel 1
        step("e_priority",    4'b0001, 4'b0001, 4'b0000, 4'b0110, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        step("e_stop0",       4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("e_inconsist1",  4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        step("e_latched",     4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        step("e_clr1",        4'b0000, 4'b0000, 4'b0010, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Commands toward an already-reached limit are ignored
        step("f_ignore_close2", 4'b0000, 4'b0100, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_still_idle2",   4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_ignore_open3",  4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_clr_in_idle",   4'b0000, 4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
